// File: rtl/byte_lb_bridge_pkg.sv
// Shared types and defaults for the byte-stream to LocalBus bridge.
// Holds the FSM state encoding and the default command/timeout constants.
package byte_lb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_WDATA   = 3'd3,
    ST_WR_STB  = 3'd4,
    ST_RD_STB  = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_TX      = 3'd7
  } state_e;

  localparam logic [7:0]  CMD_WR_DEF       = 8'hF0;
  localparam logic [7:0]  CMD_RD_DEF       = 8'hF1;
  localparam logic [15:0] TIMEOUT_CYC_DEF  = 16'd1023;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

  // Dword address step; wraps modulo 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/byte_lb_bridge_if.sv
// Byte-stream (rx/tx) and LocalBus signal bundle for byte_lb_bridge.
// master = bridge side, slave = UART FIFOs plus LocalBus target side.
interface byte_lb_bridge_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic        busy;

  modport master (
    input  rx_byte, rx_valid, tx_ready, lb_rd_d, lb_rd_rdy,
    output rx_ready, tx_byte, tx_valid, lb_wr, lb_rd, lb_addr, lb_wr_d, busy
  );

  modport slave (
    output rx_byte, rx_valid, tx_ready, lb_rd_d, lb_rd_rdy,
    input  rx_ready, tx_byte, tx_valid, lb_wr, lb_rd, lb_addr, lb_wr_d, busy
  );
endinterface

// File: rtl/byte_lb_bridge_shift.sv
// lb_byte_shift: 4-byte shift register with a byte index, used to assemble
// write dwords from rx bytes and to serialize read dwords MSB first.
module lb_byte_shift (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] data,
  output logic [1:0]  idx
);

  logic [31:0] data_r;
  logic [1:0]  idx_r;

  // Parallel load restarts the index; each shift moves one byte toward the MSB end.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= 32'd0;
      idx_r  <= 2'd0;
    end else if (load) begin
      data_r <= din;
      idx_r  <= 2'd0;
    end else if (shift) begin
      data_r <= {data_r[23:0], byte_in};
      idx_r  <= idx_r + 2'd1;
    end else begin
      data_r <= data_r;
      idx_r  <= idx_r;
    end
  end

  assign data = data_r;
  assign idx  = idx_r;

endmodule

// File: rtl/byte_lb_bridge.sv
// byte_lb_bridge: parses CMD/ADDR/LEN byte frames into LocalBus burst writes/reads and
// streams read dwords back MSB first. Optional read timeout: LB_BRIDGE_TIMEOUT_EN.
module byte_lb_bridge
  import byte_lb_pkg::*;
#(
  parameter logic [7:0]  CMD_WR       = CMD_WR_DEF,
  parameter logic [7:0]  CMD_RD       = CMD_RD_DEF
`ifdef LB_BRIDGE_TIMEOUT_EN
  ,
  parameter logic [15:0] TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
`endif
) (
  input  logic              clk_lb,
  input  logic              reset,
  byte_lb_bridge_if.master  bus
);

  state_e      state_r, state_s;
  logic [7:0]  count_r, count_s;
  logic        is_rd_r, is_rd_s;
  logic [1:0]  addr_cnt_r, addr_cnt_s;
  logic [31:0] lb_addr_r, lb_addr_s;
  logic [31:0] lb_wr_d_r, lb_wr_d_s;
  logic        lb_wr_r, lb_wr_s;
  logic        lb_rd_r, lb_rd_s;
  logic        tx_valid_r, tx_valid_s;
  logic        rx_ready_r, rx_ready_s;
  logic        busy_r, busy_s;
  logic        rx_fire_s, tx_fire_s;

  logic        sh_load_s, sh_shift_s;
  logic [31:0] sh_din_s;
  logic [31:0] sh_data_s;
  logic [1:0]  sh_idx_s;

`ifdef LB_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_r, tmo_s;
`endif

  lb_byte_shift u_shift (
    .clk     (clk_lb),
    .reset   (reset),
    .load    (sh_load_s),
    .din     (sh_din_s),
    .shift   (sh_shift_s),
    .byte_in (bus.rx_byte),
    .data    (sh_data_s),
    .idx     (sh_idx_s)
  );

  assign rx_fire_s = bus.rx_valid & rx_ready_r;
  assign tx_fire_s = tx_valid_r & bus.tx_ready;

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    is_rd_s    = is_rd_r;
    addr_cnt_s = addr_cnt_r;
    lb_addr_s  = lb_addr_r;
    lb_wr_d_s  = lb_wr_d_r;
    lb_wr_s    = 1'b0;
    lb_rd_s    = 1'b0;
    tx_valid_s = tx_valid_r;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    sh_din_s   = 32'd0;
`ifdef LB_BRIDGE_TIMEOUT_EN
    tmo_s      = tmo_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s && ((bus.rx_byte == CMD_WR) || (bus.rx_byte == CMD_RD))) begin
          is_rd_s    = (bus.rx_byte == CMD_RD);
          addr_cnt_s = 2'd0;
          state_s    = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_fire_s) begin
          lb_addr_s  = {lb_addr_r[23:0], bus.rx_byte};
          addr_cnt_s = addr_cnt_r + 2'd1;
          state_s    = (addr_cnt_r == 2'd3) ? ST_LEN : ST_ADDR;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_LEN: begin
        if (rx_fire_s) begin
          count_s   = bus.rx_byte;
          sh_load_s = 1'b1;
          if (is_rd_r) begin
            lb_rd_s = 1'b1;
            state_s = ST_RD_STB;
          end else begin
            state_s = ST_WDATA;
          end
        end else begin
          state_s = ST_LEN;
        end
      end
      ST_WDATA: begin
        if (rx_fire_s) begin
          sh_shift_s = 1'b1;
          if (sh_idx_s == 2'd3) begin
            lb_wr_s   = 1'b1;
            lb_wr_d_s = {sh_data_s[23:0], bus.rx_byte};
            state_s   = ST_WR_STB;
          end else begin
            state_s = ST_WDATA;
          end
        end else begin
          state_s = ST_WDATA;
        end
      end
      ST_WR_STB: begin
        lb_addr_s = next_addr(lb_addr_r);
        if (count_r == 8'd0) begin
          state_s = ST_IDLE;
        end else begin
          count_s = count_r - 8'd1;
          state_s = ST_WDATA;
        end
      end
      ST_RD_STB: begin
        // lb_rd_rdy coinciding with the strobe itself is deliberately not looked at.
        state_s = ST_RD_WAIT;
`ifdef LB_BRIDGE_TIMEOUT_EN
        tmo_s   = 16'd0;
`endif
      end
      ST_RD_WAIT: begin
        if (bus.lb_rd_rdy) begin
          sh_load_s  = 1'b1;
          sh_din_s   = bus.lb_rd_d;
          tx_valid_s = 1'b1;
          state_s    = ST_TX;
`ifdef LB_BRIDGE_TIMEOUT_EN
        end else if (tmo_r == (TIMEOUT_CYC - 16'd1)) begin
          sh_load_s  = 1'b1;
          sh_din_s   = TIMEOUT_DATA;
          tx_valid_s = 1'b1;
          state_s    = ST_TX;
        end else begin
          tmo_s   = tmo_r + 16'd1;
          state_s = ST_RD_WAIT;
        end
`else
        end else begin
          state_s = ST_RD_WAIT;
        end
`endif
      end
      ST_TX: begin
        if (tx_fire_s) begin
          sh_shift_s = 1'b1;
          if (sh_idx_s == 2'd3) begin
            tx_valid_s = 1'b0;
            lb_addr_s  = next_addr(lb_addr_r);
            if (count_r == 8'd0) begin
              state_s = ST_IDLE;
            end else begin
              count_s = count_r - 8'd1;
              lb_rd_s = 1'b1;
              state_s = ST_RD_STB;
            end
          end else begin
            state_s = ST_TX;
          end
        end else begin
          state_s = ST_TX;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        tx_valid_s = 1'b0;
      end
    endcase

    rx_ready_s = (state_s == ST_IDLE) || (state_s == ST_ADDR) ||
                 (state_s == ST_LEN)  || (state_s == ST_WDATA);
    busy_s     = (state_s != ST_IDLE);
  end

  // State and output registers; reset drops any partial frame or pending tx byte.
  always_ff @(posedge clk_lb) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= 8'd0;
      is_rd_r    <= 1'b0;
      addr_cnt_r <= 2'd0;
      lb_addr_r  <= 32'd0;
      lb_wr_d_r  <= 32'd0;
      lb_wr_r    <= 1'b0;
      lb_rd_r    <= 1'b0;
      tx_valid_r <= 1'b0;
      rx_ready_r <= 1'b0;
      busy_r     <= 1'b0;
`ifdef LB_BRIDGE_TIMEOUT_EN
      tmo_r      <= 16'd0;
`endif
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      is_rd_r    <= is_rd_s;
      addr_cnt_r <= addr_cnt_s;
      lb_addr_r  <= lb_addr_s;
      lb_wr_d_r  <= lb_wr_d_s;
      lb_wr_r    <= lb_wr_s;
      lb_rd_r    <= lb_rd_s;
      tx_valid_r <= tx_valid_s;
      rx_ready_r <= rx_ready_s;
      busy_r     <= busy_s;
`ifdef LB_BRIDGE_TIMEOUT_EN
      tmo_r      <= tmo_s;
`endif
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.tx_byte  = sh_data_s[31:24];
  assign bus.tx_valid = tx_valid_r;
  assign bus.lb_wr    = lb_wr_r;
  assign bus.lb_rd    = lb_rd_r;
  assign bus.lb_addr  = lb_addr_r;
  assign bus.lb_wr_d  = lb_wr_d_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_byte_lb_bridge.sv
// Directed self-checking bench for byte_lb_bridge: writes, reads, resync, wrap, tx stall, reset.
// Inputs change 2 ns after the rising edge; outputs are logged on the falling edge.
module tb_byte_lb_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  byte_lb_bridge_if bus();

  byte_lb_bridge dut (
    .clk_lb (clk),
    .reset  (reset),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] rd_resp_q[$];
  logic [7:0]  frame[$];
  logic [31:0] exp_tx[$];
  logic        slave_en = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    k = 0;
    while (!bus.rx_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check_val("rx_stall", 32'(k), 32'd0);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (bus.busy && k < limit) begin
      tick();
      k++;
    end
    check_val("idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_tx(input string tag);
    check_val({tag, "_n"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    foreach (exp_tx[i]) check_val(tag, qget(tx_q, i), exp_tx[i]);
  endtask

  // Bus activity logger.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.lb_wr) begin
        wr_addr_q.push_back(bus.lb_addr);
        wr_data_q.push_back(bus.lb_wr_d);
      end
      if (bus.lb_rd) rd_addr_q.push_back(bus.lb_addr);
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back({24'd0, bus.tx_byte});
    end
  end

  // LocalBus read target: rdy pulse 3 cycles after each lb_rd.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.lb_rd && slave_en) begin
        repeat (3) tick();
        bus.lb_rd_d   = (rd_resp_q.size() > 0) ? rd_resp_q.pop_front() : 32'h0;
        bus.lb_rd_rdy = 1'b1;
        tick();
        bus.lb_rd_rdy = 1'b0;
      end
    end
  end

  initial begin
    int k;
    bus.rx_byte   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.tx_ready  = 1'b1;
    bus.lb_rd_d   = 32'h0;
    bus.lb_rd_rdy = 1'b0;

    // Reset values
    repeat (3) tick();
    check_val("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check_val("rst_busy",     32'(bus.busy),     32'd0);
    check_val("rst_lb_wr",    32'(bus.lb_wr),    32'd0);
    check_val("rst_lb_rd",    32'(bus.lb_rd),    32'd0);
    check_val("rst_lb_addr",  bus.lb_addr,       32'd0);
    check_val("rst_lb_wr_d",  bus.lb_wr_d,       32'd0);
    check_val("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_val("rst_tx_byte",  32'(bus.tx_byte),  32'd0);
    reset = 1'b0;
    tick();
    check_val("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);

    // 1: single write
    clear_logs();
    frame = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame();
    wait_idle(200);
    check_val("t1_wr_n",    32'(wr_addr_q.size()), 32'd1);
    check_val("t1_wr_addr", qget(wr_addr_q, 0), 32'h0000_0000);
    check_val("t1_wr_data", qget(wr_data_q, 0), 32'h1234_5678);
    check_val("t1_tx_n",    32'(tx_q.size()), 32'd0);

    // 2: two-dword read
    clear_logs();
    rd_resp_q = '{32'hAAAA_0001, 32'hAAAA_0002};
    frame = '{8'hF1, 8'h00, 8'h00, 8'h00, 8'h04, 8'h01};
    send_frame();
    wait_idle(500);
    check_val("t2_rd_n",  32'(rd_addr_q.size()), 32'd2);
    check_val("t2_rd_a0", qget(rd_addr_q, 0), 32'h0000_0004);
    check_val("t2_rd_a1", qget(rd_addr_q, 1), 32'h0000_0008);
    exp_tx = '{32'hAA, 32'hAA, 32'h00, 32'h01, 32'hAA, 32'hAA, 32'h00, 32'h02};
    check_tx("t2_tx");
    check_val("t2_addr_end", bus.lb_addr, 32'h0000_000C);
    check_val("t2_wr_n", 32'(wr_addr_q.size()), 32'd0);

    // 3: garbage bytes are discarded
    clear_logs();
    send_byte(8'h00);
    send_byte(8'hFF);
    tick();
    check_val("t3_busy_garbage", 32'(bus.busy), 32'd0);
    frame = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'h40, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame();
    wait_idle(200);
    check_val("t3_wr_n",    32'(wr_addr_q.size()), 32'd1);
    check_val("t3_wr_addr", qget(wr_addr_q, 0), 32'h1122_3340);
    check_val("t3_wr_data", qget(wr_data_q, 0), 32'hCAFE_BABE);

    // 4: burst write across the 2^32 wrap
    clear_logs();
    frame = '{8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 8'h01,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame();
    wait_idle(200);
    check_val("t4_wr_n",  32'(wr_addr_q.size()), 32'd2);
    check_val("t4_a0",    qget(wr_addr_q, 0), 32'hFFFF_FFFC);
    check_val("t4_d0",    qget(wr_data_q, 0), 32'h0102_0304);
    check_val("t4_a1",    qget(wr_addr_q, 1), 32'h0000_0000);
    check_val("t4_d1",    qget(wr_data_q, 1), 32'h0506_0708);
    check_val("t4_addr_end", bus.lb_addr, 32'h0000_0004);

    // 5: tx back-pressure holds byte and valid
    clear_logs();
    bus.tx_ready = 1'b0;
    rd_resp_q = '{32'h5555_AAAA};
    frame = '{8'hF1, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    send_frame();
    k = 0;
    while (!bus.tx_valid && k < 100) begin
      tick();
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      check_val("t5_hold_valid", 32'(bus.tx_valid), 32'd1);
      check_val("t5_hold_byte",  32'(bus.tx_byte),  32'h55);
      tick();
    end
    check_val("t5_rd_n_stall", 32'(rd_addr_q.size()), 32'd1);
    bus.tx_ready = 1'b1;
    wait_idle(200);
    exp_tx = '{32'h55, 32'h55, 32'hAA, 32'hAA};
    check_tx("t5_tx");
    check_val("t5_rd_n",    32'(rd_addr_q.size()), 32'd1);
    check_val("t5_rd_addr", qget(rd_addr_q, 0), 32'h0000_0100);
    check_val("t5_addr_end", bus.lb_addr, 32'h0000_0104);

`ifdef LB_BRIDGE_TIMEOUT_EN
    // 6a: silent slave yields the timeout dword
    clear_logs();
    slave_en = 1'b0;
    frame = '{8'hF1, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
    send_frame();
    wait_idle(3000);
    exp_tx = '{32'hDE, 32'hAD, 32'hBE, 32'hEF};
    check_tx("t6_tmo_tx");
    slave_en = 1'b1;
`endif

    // 6b: reset in the middle of the address bytes
    clear_logs();
    send_byte(8'hF0);
    send_byte(8'h00);
    send_byte(8'h00);
    check_val("t6_busy_mid", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    tick();
    check_val("t6_busy_rst", 32'(bus.busy), 32'd0);
    check_val("t6_ready_rst", 32'(bus.rx_ready), 32'd0);
    reset = 1'b0;
    tick();
    check_val("t6_ready_after", 32'(bus.rx_ready), 32'd1);
    frame = '{8'hF0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    send_frame();
    wait_idle(200);
    check_val("t6_wr_n",    32'(wr_addr_q.size()), 32'd1);
    check_val("t6_wr_addr", qget(wr_addr_q, 0), 32'h0000_0020);
    check_val("t6_wr_data", qget(wr_data_q, 0), 32'h0B0C_0D0E);
    check_val("t6_rd_n",    32'(rd_addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
